// File: rtl/lfsr_gen_pkg.sv
// lfsr_gen_pkg: shared length/step limits and the per-length tap table for lfsr_gen.
// Contents:
//   LFSR_MIN_LEN, LFSR_MAX_LEN  legal register widths
//   LFSR_MAX_STEPS              largest number of shifts per transfer
//   taps(length)                16-bit feedback tap mask, bit i set when state bit i is a tap
package lfsr_gen_pkg;

    localparam int LFSR_MIN_LEN   = 3;
    localparam int LFSR_MAX_LEN   = 16;
    localparam int LFSR_MAX_STEPS = 8;

    function automatic logic [15:0] taps(input int length);
        case (length)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_gen_step.sv
// lfsr_gen_step: one combinational LFSR shift (state in, state out).
// Ports:
//   state       in   LENGTH  current register value
//   state_next  out  LENGTH  value after a single left shift with feedback in bit 0
// Parameters: LENGTH (3..16), FULL_CYCLE (1 = the all-zero state is part of the cycle).
module lfsr_gen_step
    import lfsr_gen_pkg::*;
#(
    parameter int LENGTH     = 6,
    parameter int FULL_CYCLE = 1
) (
    input  logic [LENGTH-1:0] state,
    output logic [LENGTH-1:0] state_next
);

    localparam logic [15:0] TAP_MASK = taps(LENGTH);

    logic lockup;
    logic din;

    // Flipping the feedback when all bits below the MSB are zero splices the
    // all-zero state into the maximal-length cycle (de Bruijn extension).
    always_comb begin
        lockup     = (FULL_CYCLE != 0) ? ~|state[LENGTH-2:0] : 1'b0;
        din        = ^(state & TAP_MASK[LENGTH-1:0]) ^ lockup;
        state_next = {state[LENGTH-2:0], din};
    end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: multi-step LFSR pattern generator with seed load, valid/ready output and optional wrap pulse.
// Ports:
//   clock      in   1       rising-edge clock
//   reset      in   1       synchronous active-high reset
//   load       in   1       load seed into the state on this edge (beats a transfer)
//   seed       in   LENGTH  seed value; zero becomes all-ones when FULL_CYCLE = 0
//   out_ready  in   1       consumer takes dout this cycle
//   out_valid  out  1       dout holds a valid pattern word
//   dout       out  LENGTH  current LFSR state
//   dout_next  out  LENGTH  state STEPS shifts ahead of dout (combinational)
//   wrap       out  1       one-cycle pulse after the transfer that crosses the period boundary
// Build option: define LFSR_GEN_WRAP_EN to build the period counter; otherwise wrap is tied low.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int LENGTH     = 6,
    parameter int STEPS      = 1,
    parameter int FULL_CYCLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [LENGTH-1:0] seed,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [LENGTH-1:0] dout,
    output logic [LENGTH-1:0] dout_next,
    output logic              wrap
);

    if (LENGTH < LFSR_MIN_LEN || LENGTH > LFSR_MAX_LEN || STEPS < 1 || STEPS > LFSR_MAX_STEPS) begin : g_bad_param
        $error("lfsr_gen: LENGTH must be 3..16 and STEPS 1..8");
    end

    logic [STEPS:0][LENGTH-1:0] chain;
    logic [LENGTH-1:0]          seed_eff;
    logic                       fire;

    assign chain[0]  = dout;
    assign dout_next = chain[STEPS];
    assign fire      = out_valid & out_ready;
    // Without the full cycle, all-zero would lock the register up.
    assign seed_eff  = (FULL_CYCLE == 0 && seed == '0) ? '1 : seed;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        lfsr_gen_step #(
            .LENGTH     (LENGTH),
            .FULL_CYCLE (FULL_CYCLE)
        ) u_step (
            .state      (chain[i]),
            .state_next (chain[i+1])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout      <= '1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            if (load)
                dout <= seed_eff;
            else if (fire)
                dout <= dout_next;
        end
    end

`ifdef LFSR_GEN_WRAP_EN
    localparam int PERIOD = (FULL_CYCLE != 0) ? 2 ** LENGTH : 2 ** LENGTH - 1;

    logic [LENGTH-1:0] count;
    logic [LENGTH+1:0] count_sum;
    logic              cross;

    // Two extra bits so count + STEPS and PERIOD (up to 2^16) compare without overflow.
    assign count_sum = {2'b00, count} + (LENGTH+2)'(STEPS);
    assign cross     = count_sum >= (LENGTH+2)'(PERIOD);

    always_ff @(posedge clock) begin
        if (reset || load) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (fire) begin
            count <= cross ? LENGTH'(count_sum - (LENGTH+2)'(PERIOD)) : count_sum[LENGTH-1:0];
            wrap  <= cross;
        end else begin
            wrap  <= 1'b0;
        end
    end
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: self-checking bench for lfsr_gen (table vectors, directed corner cases, random vs. position model).
module tb_lfsr_gen;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       ld_a = 0, rdy_a = 0, valid_a, wrap_a;
    logic [3:0] seed_a = 0, dout_a, next_a;
    logic       ld_b = 0, rdy_b = 0, valid_b, wrap_b;
    logic [3:0] seed_b = 0, dout_b, next_b;
    logic       ld_c = 0, rdy_c = 0, valid_c, wrap_c;
    logic [7:0] seed_c = 0, dout_c, next_c;
    logic       ld_d = 0, rdy_d = 0, valid_d, wrap_d;
    logic [10:0] seed_d = 0, dout_d, next_d;

    lfsr_gen #(.LENGTH(4), .STEPS(1), .FULL_CYCLE(1)) u_a (
        .clock(clock), .reset(reset), .load(ld_a), .seed(seed_a), .out_ready(rdy_a),
        .out_valid(valid_a), .dout(dout_a), .dout_next(next_a), .wrap(wrap_a));
    lfsr_gen #(.LENGTH(4), .STEPS(2), .FULL_CYCLE(1)) u_b (
        .clock(clock), .reset(reset), .load(ld_b), .seed(seed_b), .out_ready(rdy_b),
        .out_valid(valid_b), .dout(dout_b), .dout_next(next_b), .wrap(wrap_b));
    lfsr_gen #(.LENGTH(8), .STEPS(1), .FULL_CYCLE(0)) u_c (
        .clock(clock), .reset(reset), .load(ld_c), .seed(seed_c), .out_ready(rdy_c),
        .out_valid(valid_c), .dout(dout_c), .dout_next(next_c), .wrap(wrap_c));
    lfsr_gen #(.LENGTH(11), .STEPS(5), .FULL_CYCLE(0)) u_d (
        .clock(clock), .reset(reset), .load(ld_d), .seed(seed_d), .out_ready(rdy_d),
        .out_valid(valid_d), .dout(dout_d), .dout_next(next_d), .wrap(wrap_d));

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // wrap only exists when the counter is built
    function automatic bit wexp(input bit w);
`ifdef LFSR_GEN_WRAP_EN
        return w;
`else
        return 1'b0;
`endif
    endfunction

    // One shift by the textual rule: shift left, feedback = XOR of listed taps, lockup fix.
    function automatic int ref_step(input int s, input int len, input bit fc);
        int fb;
        case (len)
            4:       fb = (s >> 3 ^ s >> 2) & 1;
            8:       fb = (s >> 7 ^ s >> 5 ^ s >> 4 ^ s >> 3) & 1;
            default: fb = (s >> 10 ^ s >> 8) & 1;
        endcase
        if (fc && (s % (1 << (len - 1))) == 0) fb ^= 1;
        return ((s << 1) | fb) % (1 << len);
    endfunction

    typedef struct {
        bit         ld;
        logic [3:0] seed;
        bit         rdy;
        logic [3:0] dout;
        bit         valid;
        bit         wrap;
    } vec_t;

    vec_t vecs[23];
    int   seq11[2047];
    int   pos11[2048];
    bit   seen[256];

    initial begin
        int prev, exp, distinct, zero_seen, st, idx, p;
        longint n;
        bit valid_m, wrap_m, fire, rst, ld, rdy;
        logic [10:0] sd;
        int seqb[9] = '{4'hF, 4'hC, 4'h0, 4'h2, 4'h9, 4'h6, 4'hA, 4'hB, 4'hF};

        // ld, seed, rdy -> expected dout, valid, wrap after the edge
        vecs[0]  = '{0, 4'h0, 1, 4'hF, 1, 0};
        vecs[1]  = '{0, 4'h0, 1, 4'hE, 1, 0};
        vecs[2]  = '{0, 4'h0, 1, 4'hC, 1, 0};
        vecs[3]  = '{0, 4'h0, 1, 4'h8, 1, 0};
        vecs[4]  = '{0, 4'h0, 1, 4'h0, 1, 0};
        vecs[5]  = '{0, 4'h0, 1, 4'h1, 1, 0};
        vecs[6]  = '{0, 4'h0, 1, 4'h2, 1, 0};
        vecs[7]  = '{0, 4'h0, 1, 4'h4, 1, 0};
        vecs[8]  = '{0, 4'h0, 1, 4'h9, 1, 0};
        vecs[9]  = '{0, 4'h0, 1, 4'h3, 1, 0};
        vecs[10] = '{0, 4'h0, 1, 4'h6, 1, 0};
        vecs[11] = '{0, 4'h0, 1, 4'hD, 1, 0};
        vecs[12] = '{0, 4'h0, 1, 4'hA, 1, 0};
        vecs[13] = '{0, 4'h0, 1, 4'h5, 1, 0};
        vecs[14] = '{0, 4'h0, 1, 4'hB, 1, 0};
        vecs[15] = '{0, 4'h0, 1, 4'h7, 1, 0};
        vecs[16] = '{0, 4'h0, 1, 4'hF, 1, 1};
        vecs[17] = '{0, 4'h0, 1, 4'hE, 1, 0};
        vecs[18] = '{1, 4'hA, 1, 4'hA, 1, 0};
        vecs[19] = '{0, 4'h0, 0, 4'hA, 1, 0};
        vecs[20] = '{0, 4'h0, 1, 4'h5, 1, 0};
        vecs[21] = '{1, 4'h0, 0, 4'h0, 1, 0};
        vecs[22] = '{0, 4'h0, 1, 4'h1, 1, 0};

        // reset state
        tick();
        tick();
        check("rst_dout_a", dout_a, 4'hF);
        check("rst_valid_a", valid_a, 0);
        check("rst_wrap_a", wrap_a, 0);
        check("rst_dout_c", dout_c, 8'hFF);
        check("rst_valid_c", valid_c, 0);
        reset = 0;
        #1;
        check("first_cycle_valid_a", valid_a, 0);

        // table-driven: LENGTH=4 full cycle, single step
        for (int i = 0; i < 23; i++) begin
            ld_a = vecs[i].ld;
            seed_a = vecs[i].seed;
            rdy_a = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_dout", i), dout_a, vecs[i].dout);
            check($sformatf("vec%0d_valid", i), valid_a, vecs[i].valid);
            check($sformatf("vec%0d_wrap", i), wrap_a, wexp(vecs[i].wrap));
        end
        ld_a = 0;
        rdy_a = 0;

        // STEPS=2 sequence
        check("b_next_initial", next_b, 4'hC);
        rdy_b = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("b_seq%0d", k), dout_b, seqb[k]);
            check($sformatf("b_wrap%0d", k), wrap_b, wexp(k == 8));
        end
        rdy_b = 0;

        // LENGTH=8 FULL_CYCLE=0 full period with a mid-sequence stall
        prev = 'hFF;
        distinct = 0;
        zero_seen = 0;
        foreach (seen[i]) seen[i] = 0;
        rdy_c = 1;
        for (int k = 1; k <= 255; k++) begin
            if (k == 100) begin
                rdy_c = 0;
                for (int j = 0; j < 5; j++) begin
                    tick();
                    check("c_stall_dout", dout_c, prev);
                    check("c_stall_wrap", wrap_c, 0);
                end
                rdy_c = 1;
            end
            tick();
            exp = ref_step(prev, 8, 0);
            check("c_seq", dout_c, exp);
            check("c_wrap", wrap_c, wexp(k == 255));
            if (dout_c == 0) zero_seen++;
            if (!seen[int'(dout_c)]) begin
                seen[int'(dout_c)] = 1;
                distinct++;
            end
            prev = exp;
        end
        rdy_c = 0;
        check("c_distinct", distinct, 255);
        check("c_zero_seen", zero_seen, 0);
        check("c_end_state", dout_c, 8'hFF);
        tick();
        check("c_wrap_one_cycle", wrap_c, 0);

        // zero seed replaced by all-ones; load beats a simultaneous fire
        ld_c = 1; seed_c = 8'h00; rdy_c = 0;
        tick();
        check("c_zero_seed", dout_c, 8'hFF);
        seed_c = 8'h5A; rdy_c = 1;
        tick();
        check("c_load_vs_fire", dout_c, 8'h5A);
        ld_c = 0;
        tick();
        check("c_after_load", dout_c, ref_step('h5A, 8, 0));
        rdy_c = 0;

        // reset together with load
        reset = 1; ld_a = 1; seed_a = 4'h5; rdy_a = 1;
        tick();
        check("rl_dout", dout_a, 4'hF);
        check("rl_valid", valid_a, 0);
        reset = 0; ld_a = 0;
        #1;
        check("rl_valid_first", valid_a, 0);
        tick();
        check("rl_valid_second", valid_a, 1);
        check("rl_dout_hold", dout_a, 4'hF);
        tick();
        check("rl_first_fire", dout_a, 4'hE);
        rdy_a = 0;

        // position model for LENGTH=11 FULL_CYCLE=0 STEPS=5
        p = 2047;
        pos11[0] = -1;
        st = 'h7FF;
        for (int i = 0; i < p; i++) begin
            seq11[i] = st;
            pos11[st] = i;
            st = ref_step(st, 11, 0);
        end
        idx = 0; n = 0; valid_m = 0; wrap_m = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 15) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            reset = rst; ld_d = ld; seed_d = sd; rdy_d = rdy;
            #1;
            if (cyc > 0) check("d_next", next_d, seq11[(idx + 5) % p]);
            fire = valid_m & rdy;
            if (rst) begin
                idx = 0; n = 0; valid_m = 0; wrap_m = 0;
            end else begin
                valid_m = 1;
                if (ld) begin
                    idx = pos11[(sd == 0) ? 'h7FF : int'(sd)];
                    n = 0;
                    wrap_m = 0;
                end else if (fire) begin
                    wrap_m = ((n + 5) / p) != (n / p);
                    n += 5;
                    idx = (idx + 5) % p;
                end else begin
                    wrap_m = 0;
                end
            end
            tick();
            check("d_dout", dout_d, seq11[idx]);
            check("d_valid", valid_d, valid_m);
            check("d_wrap", wrap_d, wexp(wrap_m));
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
